// File: rtl/game_flow_ctrl.sv
// Game-flow controller: WELCOME -> START -> PLAY <-> PAUSE -> FINISH, with
// frame-strobed team-name editing driven by press edges on OR-combined player buttons.
module game_flow_ctrl #(
  parameter int NAME_LEN     = 3,
  parameter int NUM_PLAYERS  = 4,
  parameter int START_FRAMES = 300,
  parameter int FINISH_HOLD  = 60,
  parameter int TIME_W       = 8,
  localparam int CUR_W = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1,
  localparam int CNT_W = $clog2(START_FRAMES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame,
  input  logic [NUM_PLAYERS-1:0] btn_left,
  input  logic [NUM_PLAYERS-1:0] btn_right,
  input  logic [NUM_PLAYERS-1:0] btn_up,
  input  logic [NUM_PLAYERS-1:0] btn_down,
  input  logic [NUM_PLAYERS-1:0] btn_chop,
  input  logic                   pause,
  input  logic [TIME_W-1:0]      time_left,
  output logic [2:0]             game_state,
  output logic [NAME_LEN*8-1:0]  team_name,
  output logic [CUR_W-1:0]       cursor,
  output logic [CNT_W-1:0]       start_count,
  output logic                   timer_run,
  output logic                   game_over
);

  localparam int HOLD_W = (FINISH_HOLD > 0) ? $clog2(FINISH_HOLD + 1) : 1;
  localparam int BASE_W = (NAME_LEN * 8 > 2) ? $clog2(NAME_LEN * 8) : 1;

  typedef enum logic [2:0] {
    WELCOME = 3'd0,
    START   = 3'd1,
    PLAY    = 3'd2,
    PAUSE   = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t            state;
  logic [4:0]        active;
  logic [4:0]        prev;
  logic [4:0]        press;
  logic [HOLD_W-1:0] hold;
  logic [BASE_W-1:0] base;
  logic [7:0]        letter;
  logic [7:0]        letter_up;
  logic [7:0]        letter_down;
  logic              at_last;
  logic              confirm;

  // Button bit order is {chop, up, down, right, left}, which is also the priority order.
  assign active     = {|btn_chop, |btn_up, |btn_down, |btn_right, |btn_left};
  assign press      = active & ~prev;
  assign game_state = state;
  assign at_last    = (cursor == CUR_W'(NAME_LEN - 1));
  assign confirm    = press[4] | (~press[3] & ~press[2] & press[1] & at_last);

  // Cursor 0 is the leftmost letter, held in the most significant byte.
  always_comb begin
    base        = BASE_W'((NAME_LEN - 1 - int'(cursor)) * 8);
    letter      = team_name[base +: 8];
    letter_up   = (letter == 8'h41) ? 8'h5A : letter - 8'd1;
    letter_down = (letter == 8'h5A) ? 8'h41 : letter + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WELCOME;
      team_name   <= {NAME_LEN{8'h41}};
      cursor      <= '0;
      start_count <= '0;
      timer_run   <= 1'b0;
      game_over   <= 1'b0;
      hold        <= '0;
      prev        <= '1;
    end else begin
      game_over <= 1'b0;
      if (frame) begin
        prev <= active;
        case (state)
          WELCOME: begin
            if (confirm) begin
              state       <= START;
              start_count <= CNT_W'(START_FRAMES);
              cursor      <= '0;
            end else if (press[3]) begin
              team_name[base +: 8] <= letter_up;
            end else if (press[2]) begin
              team_name[base +: 8] <= letter_down;
            end else if (press[1]) begin
              cursor <= cursor + 1'b1;
            end else if (press[0] && cursor != '0) begin
              cursor <= cursor - 1'b1;
            end
          end
          START: begin
            if (start_count <= CNT_W'(1)) begin
              state       <= PLAY;
              timer_run   <= 1'b1;
              start_count <= '0;
            end else begin
              start_count <= start_count - 1'b1;
            end
          end
          PLAY: begin
            if (time_left == '0) begin
              state     <= FINISH;
              timer_run <= 1'b0;
              game_over <= 1'b1;
              hold      <= HOLD_W'(FINISH_HOLD);
            end else if (pause) begin
              state     <= PAUSE;
              timer_run <= 1'b0;
            end
          end
          PAUSE: begin
            if (!pause) begin
              state     <= PLAY;
              timer_run <= 1'b1;
            end
          end
          FINISH: begin
            if (hold != '0) begin
              hold <= hold - 1'b1;
            end else if (|press) begin
              state  <= WELCOME;
              cursor <= '0;
            end
          end
          default: begin
            state       <= WELCOME;
            timer_run   <= 1'b0;
            cursor      <= '0;
            start_count <= '0;
          end
        endcase
      end
    end
  end

endmodule
